// File: rtl/alu_seq.sv
// Registered 16-opcode ALU with Z/C/V/P flags behind a valid/ready output register.
// Define ALU_SEQ_MUL_EN to build opcode F as a WIDTH-cycle shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             p
);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_INC = 4'h2, OP_DEC = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8, OP_SHR = 4'h9, OP_ASR = 4'hA, OP_ROL = 4'hB;
  localparam logic [3:0] OP_ROR = 4'hC, OP_PAS = 4'hD, OP_NEG = 4'hE, OP_MUL = 4'hF;

  function automatic logic parity_of(input logic [WIDTH-1:0] x);
    return ^x;
  endfunction

  logic             accept_s;
  logic             load_alu_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_res_s;
  logic             mul_c_s;
  logic [WIDTH-1:0] alu_res_s;
  logic             alu_c_s;
  logic             alu_v_s;

  assign accept_s = in_valid && in_ready;

  // Single-cycle datapath; opcode F falls to the zero default when no multiplier is built.
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (opcode)
      OP_ADD: begin
        {alu_c_s, alu_res_s} = {1'b0, a} + {1'b0, b};
        alu_v_s = (a[WIDTH-1] == b[WIDTH-1]) && (alu_res_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res_s = a - b;
        alu_c_s   = (a < b);
        alu_v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (alu_res_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_INC: begin
        {alu_c_s, alu_res_s} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
        alu_v_s = !a[WIDTH-1] && alu_res_s[WIDTH-1];
      end
      OP_DEC: begin
        alu_res_s = a - {{(WIDTH-1){1'b0}}, 1'b1};
        alu_c_s   = (a == {WIDTH{1'b0}});
        alu_v_s   = a[WIDTH-1] && !alu_res_s[WIDTH-1];
      end
      OP_AND: alu_res_s = a & b;
      OP_OR:  alu_res_s = a | b;
      OP_XOR: alu_res_s = a ^ b;
      OP_NOT: alu_res_s = ~a;
      OP_SHL: begin alu_res_s = {a[WIDTH-2:0], 1'b0};       alu_c_s = a[WIDTH-1]; end
      OP_SHR: begin alu_res_s = {1'b0, a[WIDTH-1:1]};       alu_c_s = a[0];       end
      OP_ASR: begin alu_res_s = {a[WIDTH-1], a[WIDTH-1:1]}; alu_c_s = a[0];       end
      OP_ROL: begin alu_res_s = {a[WIDTH-2:0], a[WIDTH-1]}; alu_c_s = a[WIDTH-1]; end
      OP_ROR: begin alu_res_s = {a[0], a[WIDTH-1:1]};       alu_c_s = a[0];       end
      OP_PAS: alu_res_s = a;
      OP_NEG: begin
        alu_res_s = {WIDTH{1'b0}} - a;
        alu_c_s   = |a;
        alu_v_s   = a[WIDTH-1] && alu_res_s[WIDTH-1];
      end
      default: begin
        alu_res_s = {WIDTH{1'b0}};
        alu_c_s   = 1'b0;
        alu_v_s   = 1'b0;
      end
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_MUL = 1'b1} state_t;

  state_t             state_r;
  state_t             state_next;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [2*WIDTH-1:0] acc_next_s;
  logic               start_mul_s;

  assign in_ready    = (state_r == ST_IDLE) && (!out_valid || out_ready);
  assign start_mul_s = accept_s && (opcode == OP_MUL);
  assign load_alu_s  = accept_s && (opcode != OP_MUL);
  assign acc_next_s  = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
  assign mul_done_s  = (state_r == ST_MUL) && (cnt_r == CNT_W'(WIDTH - 1));
  assign mul_res_s   = acc_next_s[WIDTH-1:0];
  assign mul_c_s     = |acc_next_s[2*WIDTH-1:WIDTH];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE: if (start_mul_s) state_next = ST_MUL;  else state_next = ST_IDLE;
      ST_MUL:  if (mul_done_s)  state_next = ST_IDLE; else state_next = ST_MUL;
      default: state_next = ST_IDLE;
    endcase
  end

  // Shift-add iteration; operands are latched at acceptance so input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
    end else if (start_mul_s) begin
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {{WIDTH{1'b0}}, a};
      mplier_r <= b;
      cnt_r    <= {CNT_W{1'b0}};
    end else if (state_r == ST_MUL) begin
      acc_r    <= acc_next_s;
      mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
      mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
      cnt_r    <= cnt_r + CNT_W'(1);
    end
  end
`else
  assign in_ready   = !out_valid || out_ready;
  assign load_alu_s = accept_s;
  assign mul_done_s = 1'b0;
  assign mul_res_s  = {WIDTH{1'b0}};
  assign mul_c_s    = 1'b0;
`endif

  // Output register: load wins over drain so accept and drain can share an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= {WIDTH{1'b0}};
      z         <= 1'b0;
      c         <= 1'b0;
      v         <= 1'b0;
      p         <= 1'b0;
    end else if (load_alu_s) begin
      out_valid <= 1'b1;
      result    <= alu_res_s;
      z         <= (alu_res_s == {WIDTH{1'b0}});
      c         <= alu_c_s;
      v         <= alu_v_s;
      p         <= parity_of(alu_res_s);
    end else if (mul_done_s) begin
      out_valid <= 1'b1;
      result    <= mul_res_s;
      z         <= (mul_res_s == {WIDTH{1'b0}});
      c         <= mul_c_s;
      v         <= 1'b0;
      p         <= parity_of(mul_res_s);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed bench for alu_seq (WIDTH=8) against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 8;
`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [3:0]   opcode;
  logic         z, c, v, p;
  int           checks = 0;
  int           failures = 0;

  typedef struct packed {
    logic [7:0] res;
    logic z, c, v, p;
  } exp_t;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .z(z), .c(c), .v(v), .p(p)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference computed from integer arithmetic on the operand values.
  function automatic exp_t ref_model(input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib);
    int ua = ia, ub = ib, sa = $signed(ia), sb = $signed(ib);
    int full = 0, sres = 0;
    bit cy = 0, ov = 0;
    exp_t e;
    case (op)
      4'h0: begin full = ua + ub; sres = sa + sb; cy = full > 255; end
      4'h1: begin full = ua - ub; sres = sa - sb; cy = ua < ub; end
      4'h2: begin full = ua + 1;  sres = sa + 1;  cy = full > 255; end
      4'h3: begin full = ua - 1;  sres = sa - 1;  cy = ua < 1; end
      4'h4: full = ua & ub;
      4'h5: full = ua | ub;
      4'h6: full = ua ^ ub;
      4'h7: full = 255 - ua;
      4'h8: begin full = ua * 2; cy = ua >= 128; end
      4'h9: begin full = ua / 2; cy = (ua % 2) == 1; end
      4'hA: begin full = sa >>> 1; cy = (ua % 2) == 1; end
      4'hB: begin full = ua * 2 + ua / 128; cy = ua >= 128; end
      4'hC: begin full = ua / 2 + (ua % 2) * 128; cy = (ua % 2) == 1; end
      4'hD: full = ua;
      4'hE: begin full = 0 - ua; sres = -sa; cy = ua > 0; end
      default: begin
        if (MUL_EN) begin full = ua * ub; cy = full > 255; end
        else full = 0;
      end
    endcase
    if (op inside {4'h0, 4'h1, 4'h2, 4'h3, 4'hE}) ov = (sres > 127) || (sres < -128);
    e.res = full[7:0];
    e.z = (e.res == 8'h00);
    e.c = cy;
    e.v = ov;
    e.p = ($countones(e.res) % 2) == 1;
    return e;
  endfunction

  // Issue one request with out_ready=1, wait for its result, and compare against the model.
  task automatic run_op(input logic [3:0] op, input logic [7:0] ia, input logic [7:0] ib,
                        output exp_t got, output int lat);
    exp_t e;
    int   wait_n = 0;
    int   low_n = 0;
    bit   is_mul = MUL_EN && (op == 4'hF);
    e = ref_model(op, ia, ib);
    out_ready = 1'b1;
    in_valid = 1'b1; opcode = op; a = ia; b = ib;
    while (!in_ready && wait_n < 20) begin
      @(posedge clk); #1; wait_n++;
    end
    check_eq("accept_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); opcode = 4'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) low_n++;
      @(posedge clk); #1; lat++;
    end
    check_eq("out_valid", out_valid, 1'b1);
    check_eq("latency", lat, is_mul ? W : 0);
    check_eq("ready_low", low_n, is_mul ? W : 0);
    got = {result, z, c, v, p};
    check_eq("result", got.res, e.res);
    check_eq("flags", {got.z, got.c, got.v, got.p}, {e.z, e.c, e.v, e.p});
  endtask

  exp_t got;
  int   lat;
  int   seen;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; opcode = 4'h0;
    #12;
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_result", result, 8'h00);
    check_eq("rst_flags", {z, c, v, p}, 4'b0000);
    @(posedge clk); #1; rst_n = 1'b1; #1;
    check_eq("rst_in_ready", in_ready, 1'b1);

    run_op(4'h0, 8'hF0, 8'h20, got, lat);
    check_eq("add_const", {got.res, got.z, got.c, got.v, got.p}, {8'h10, 4'b0101});
    run_op(4'h1, 8'h80, 8'h01, got, lat);
    check_eq("sub_const", {got.res, got.c, got.v, got.p}, {8'h7F, 3'b011});
    run_op(4'hE, 8'h80, 8'h00, got, lat);
    check_eq("neg_const", {got.res, got.c, got.v}, {8'h80, 2'b11});
    run_op(4'hF, 8'h0F, 8'h11, got, lat);
    check_eq("mul_a", {got.res, got.z, got.c}, MUL_EN ? {8'hFF, 2'b00} : {8'h00, 2'b10});
    run_op(4'hF, 8'h10, 8'h10, got, lat);
    check_eq("mul_b", {got.res, got.z, got.c}, MUL_EN ? {8'h00, 2'b11} : {8'h00, 2'b10});
    @(posedge clk); #1;
    check_eq("drain", out_valid, 1'b0);

    // Back-to-back single-cycle ops.
    in_valid = 1'b1; opcode = 4'h2; a = 8'hFF;
    @(posedge clk); #1;
    check_eq("b2b_inc", {out_valid, result, z, c}, {1'b1, 8'h00, 2'b11});
    opcode = 4'h3; a = 8'h00;
    check_eq("b2b_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    check_eq("b2b_dec", {out_valid, result, c}, {1'b1, 8'hFF, 1'b1});
    opcode = 4'hA; a = 8'h81;
    @(posedge clk); #1;
    check_eq("b2b_asr", {out_valid, result, c}, {1'b1, 8'hC0, 1'b1});
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Backpressure: result held while the consumer stalls.
    out_ready = 1'b0; in_valid = 1'b1; opcode = 4'hB; a = 8'h81;
    @(posedge clk); #1;
    opcode = 4'h6; a = 8'hAA; b = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_hold", {out_valid, result, c, in_ready}, {1'b1, 8'h03, 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    check_eq("bp_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_xor", {out_valid, result, p}, {1'b1, 8'h55, 1'b0});
    @(posedge clk); #1;

    // Reset during opcode F; nothing stale may appear afterwards.
    out_ready = 1'b0; in_valid = 1'b1; opcode = 4'hF; a = 8'h0F; b = 8'h11;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0; #1;
    check_eq("mrst_valid", out_valid, 1'b0);
    check_eq("mrst_result", {result, z, c, v, p}, {8'h00, 4'b0000});
    @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1; #1;
    check_eq("mrst_ready", in_ready, 1'b1);
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check_eq("mrst_stale", seen, 0);

    // Random operations, operands scrambled after acceptance.
    for (int i = 0; i < 200; i++)
      run_op(4'($urandom), 8'($urandom), 8'($urandom), got, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 4-bit combinational ALU. It executes one 16-opcode operation per accepted request on WIDTH-bit operands and returns the result plus Z/C/V/P flags through a valid/ready output register. A shift-add multiplier is optionally compiled in and takes WIDTH cycles. The block sits between a datapath sequencer (producer) and a register-file write-back stage (consumer).

## Interface
- WIDTH, 8, operand/result width in bits; legal range 4..32.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present on a, b, opcode.
- in_ready  out  1  block can accept a request this cycle.
- a  in  WIDTH  operand A, unsigned/two's complement.
- b  in  WIDTH  operand B.
- opcode  in  4  operation select.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer takes the result this cycle.
- result  out  WIDTH  operation result.
- z, c, v, p  out  1 each  zero, carry, overflow and parity flags.

## Operation
- Opcode map: 0 ADD a+b; 1 SUB a-b; 2 INC a; 3 DEC a; 4 AND; 5 OR; 6 XOR; 7 NOT a; 8 SHL a by 1; 9 SHR a by 1 (logical); A ASR a by 1; B ROL a by 1; C ROR a by 1; D PASS a; E NEG (0-a); F MUL (low WIDTH bits of a*b).
- z = (result == 0). p = XOR-reduction of result (1 = odd number of ones).
- c: ADD/INC carry out; SUB/DEC/NEG = borrow (1 when the unsigned minuend < subtrahend); shifts and rotates = the bit shifted or rotated out; MUL = 1 if the upper WIDTH bits of the product are nonzero; logic ops and PASS = 0.
- v: signed overflow for ADD/SUB/INC/DEC/NEG; 0 for all other ops.
- FSM states:
  - IDLE: accepts requests.
  - MUL: iterates; a and b are captured at acceptance, so later input changes are ignored.
- Transitions: IDLE -> MUL on accepting opcode F. MUL -> IDLE after WIDTH iterations, loading the output register.
- in_ready = (state == IDLE) && (!out_valid || out_ready). A request is accepted on a rising edge when in_valid && in_ready.
- The output register holds result and flags stable while out_valid && !out_ready.
- out_valid drops on the edge where out_ready is high, unless a new result loads on that same edge (simultaneous accept and drain allowed).

## Timing
- Reset (asynchronous, any cycle, including mid-MUL):
  - state = IDLE, out_valid = 0, result = 0, z = c = v = p = 0.
  - Any in-flight multiply is discarded with no output.
  - in_ready = 1 once rst_n is high.
- Single-cycle ops: accepted at edge N -> out_valid = 1 with result after edge N.
- Sustained throughput is 1 op per cycle while out_ready = 1.
- MUL: accepted at edge N -> in_ready = 0 through edge N+WIDTH-1 -> out_valid after edge N+WIDTH.
- Arithmetic is modulo 2^WIDTH. No internal sign extension beyond WIDTH except the 2*WIDTH-bit product accumulator.

## Configuration
- ALU_SEQ_MUL_EN defined: opcode F runs the iterative multiplier as specified above.
- ALU_SEQ_MUL_EN undefined:
  - No MUL state and no accumulator.
  - Opcode F completes in 1 cycle with result = 0, z = 1, c = v = p = 0.

## Test plan
WIDTH = 8 throughout.
- ADD a=0xF0 b=0x20, out_ready=1 -> result 0x10, z=0 c=1 v=0 p=1, out_valid one cycle after accept.
- SUB a=0x80 b=0x01 -> 0x7F, c=0 v=1 p=1; NEG a=0x80 -> 0x80, v=1 c=1.
- MUL (macro defined):
  - a=0x0F b=0x11 -> 0xFF, c=0 z=0; in_ready low for 8 cycles; out_valid exactly 8 cycles after accept.
  - a=0x10 b=0x10 -> 0x00, z=1 c=1.
  - Operands changed mid-operation must not affect the result.
- Backpressure:
  - ROL a=0x81 -> 0x03 c=1; hold out_ready=0 for 3 cycles -> result/flags stable, in_ready=0.
  - Raise out_ready with in_valid=1 (XOR a=0xAA b=0xFF) -> accepted same edge, next result 0x55 p=0.
- Reset mid-MUL: assert rst_n=0 at cycle 3 of a multiply -> out_valid=0, result=0 immediately; after release in_ready=1, no stale result ever appears.
- Back-to-back: INC 0xFF, DEC 0x00, ASR 0x81 with out_ready=1 -> 0x00 z=1 c=1; 0xFF c=1; 0xC0 c=1; on consecutive cycles.
